// File: rtl/ex_muldiv_pkg.sv
// Shared EX-stage definitions for the iterative M-extension unit.
// Holds func3 encodings, FSM states and special-case result constants.
package ex_muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_neg32.sv
// Conditional two's-complement negate with a gated carry-in,
// so the upper word of a 64-bit negate can be formed from its borrow.
module neg32 (
    input  logic [31:0] a,
    input  logic        neg,
    input  logic        cin,
    output logic [31:0] y
);

    assign y = (neg ? ~a : a) + {31'd0, neg & cin};

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in EX: shift-add / restoring divide,
// 32 iterations plus one sign-fix cycle, stalling the front end while busy.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_start,
    input  logic [2:0]      ex_func3,
    input  logic [XLEN-1:0] ex_op1,
    input  logic [XLEN-1:0] ex_op2,
    input  logic [4:0]      ex_rdaddr,
    input  logic            flush,
    output logic            md_stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result,
    output logic [4:0]      md_rdaddr
);

    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [31:0] a_q;
    logic [31:0] res_q;
    logic [63:0] acc_q;
    logic        neg_q;

    logic        is_div, s1, s2, n1, n2;
    logic        div0, ovf, accept;
    logic [31:0] mag1, mag2;

    assign is_div = ex_func3[2];
    assign s1 = (ex_func3 == F3_MULH) || (ex_func3 == F3_MULHSU)
             || (ex_func3 == F3_DIV)  || (ex_func3 == F3_REM);
    assign s2 = (ex_func3 == F3_MULH) || (ex_func3 == F3_DIV)
             || (ex_func3 == F3_REM);
    assign n1 = s1 & ex_op1[31];
    assign n2 = s2 & ex_op2[31];
    assign div0 = is_div && (ex_op2 == '0);
    assign ovf = is_div && !ex_func3[0]
              && (ex_op1 == INT_MIN) && (ex_op2 == '1);
    assign accept = (state_q == S_IDLE) && ex_start && !flush;

    neg32 u_abs1 (.a(ex_op1), .neg(n1), .cin(1'b1), .y(mag1));
    neg32 u_abs2 (.a(ex_op2), .neg(n2), .cin(1'b1), .y(mag2));

    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] div_r;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_nxt;

    assign mul_sum = {1'b0, acc_q[63:32]}
                   + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    assign mul_nxt = {mul_sum, acc_q[31:1]};
    assign div_r = acc_q[63:31];
    assign div_ge = div_r >= {1'b0, a_q};
    assign div_diff = div_r[31:0] - a_q;
    assign div_nxt = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                            : {div_r[31:0], acc_q[30:0], 1'b0};

    logic        hi_sel, fix_cin;
    logic [31:0] fix_in, fix_out;

    // High-word negate needs the borrow out of the (discarded) low word
    assign hi_sel = f3_q[2] ? f3_q[1] : (f3_q != F3_MUL);
    assign fix_in = hi_sel ? acc_q[63:32] : acc_q[31:0];
    assign fix_cin = (!f3_q[2] && hi_sel) ? (acc_q[31:0] == '0) : 1'b1;

    neg32 u_fix (.a(fix_in), .neg(neg_q), .cin(fix_cin), .y(fix_out));

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        md_stall  = 1'b0;
        md_done   = 1'b0;
        md_result = '0;
        md_rdaddr = '0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_CALC;
                    md_stall = rst;
                end
            end
            S_CALC: begin
                md_stall = 1'b1;
                if (flush)               state_d = S_IDLE;
                else if (cnt_q == 6'd32) state_d = S_DONE;
            end
            S_DONE: begin
                md_done   = 1'b1;
                md_result = res_q;
                md_rdaddr = rd_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Special cases preload the final {rem, quot} and skip to the sign-fix step
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            f3_q  <= '0;
            rd_q  <= '0;
            a_q   <= '0;
            res_q <= '0;
            acc_q <= '0;
            neg_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        f3_q <= ex_func3;
                        rd_q <= ex_rdaddr;
                        if (div0) begin
                            a_q   <= '0;
                            acc_q <= {ex_op1, DIV0_Q};
                            neg_q <= 1'b0;
                            cnt_q <= 6'd32;
                        end else if (ovf) begin
                            a_q   <= '0;
                            acc_q <= {32'd0, INT_MIN};
                            neg_q <= 1'b0;
                            cnt_q <= 6'd32;
                        end else begin
                            a_q   <= is_div ? mag2 : mag1;
                            acc_q <= {32'd0, is_div ? mag1 : mag2};
                            neg_q <= (is_div && ex_func3[1]) ? n1 : (n1 ^ n2);
                            cnt_q <= '0;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        if (cnt_q == 6'd32) begin
                            res_q <= fix_out;
                        end else begin
                            acc_q <= f3_q[2] ? div_nxt : mul_nxt;
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed corner cases plus random ops
// against a plain-arithmetic reference, with flush/reset/back-to-back checks.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_start = 1'b0;
    logic [2:0]  ex_func3 = '0;
    logic [31:0] ex_op1 = '0;
    logic [31:0] ex_op2 = '0;
    logic [4:0]  ex_rdaddr = '0;
    logic        flush = 1'b0;
    logic        md_stall, md_done;
    logic [31:0] md_result;
    logic [4:0]  md_rdaddr;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .ex_start(ex_start), .ex_func3(ex_func3),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rdaddr(ex_rdaddr),
        .flush(flush), .md_stall(md_stall), .md_done(md_done),
        .md_result(md_result), .md_rdaddr(md_rdaddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc = 0;
    int   done_cnt = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h cycle=%0d", nm, got, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic        ov;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p = ea * eb;
        case (f)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && b == 0) return 2;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000
            && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Monitor: pops expected results on every md_done
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (md_done === 1'b1) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got result=%h required=no done cycle=%0d",
                         md_result, cyc);
            end else begin
                e = sbq.pop_front();
                chk("result", md_result, e.res);
                chk("rdaddr", 32'(md_rdaddr), 32'(e.rd));
                chk("latency", 32'(cyc - e.cyc), 32'(e.lat));
            end
        end else begin
            chk("idle_result_zero", md_result, 32'd0);
            chk("idle_rdaddr_zero", 32'(md_rdaddr), 32'd0);
        end
    end

    task automatic drive(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        ex_start  = 1'b1;
        ex_func3  = f;
        ex_op1    = a;
        ex_op2    = b;
        ex_rdaddr = rd;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bit got;
        bit stall_ok;
        @(negedge clk);
        drive(f, a, b, rd);
        sbq.push_back('{ref_res(f, a, b), rd, cyc, ref_lat(f, a, b)});
        #1 stall_ok = (md_stall === 1'b1);
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 0) ex_start = 1'b0;
            if (md_done === 1'b1) begin
                got = 1'b1;
                if (md_stall !== 1'b0) stall_ok = 1'b0;
                break;
            end else if (md_stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        chk("stall_profile", 32'(stall_ok), 32'd1);
        chk("done_seen", 32'(got), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int d0;
        logic [31:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(md_stall), 32'd0);
        chk("rst_done", 32'(md_done), 32'd0);
        chk("rst_result", md_result, 32'd0);
        chk("rst_rdaddr", 32'(md_rdaddr), 32'd0);
        rst = 1'b1;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2);
        issue(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        issue(3'd5, 32'd100, 32'd7, 5'd7);
        issue(3'd7, 32'd100, 32'd7, 5'd8);
        issue(3'd4, 32'd5, 32'd0, 5'd9);
        issue(3'd6, 32'd5, 32'd0, 5'd10);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

        // flush in mid-CALC aborts the DIVU
        @(negedge clk);
        drive(3'd5, 32'd1000, 32'd7, 5'd13);
        c0 = cyc;
        d0 = done_cnt;
        @(negedge clk);
        ex_start = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_stall_low", 32'(md_stall), 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_no_done", 32'(done_cnt - d0), 32'd0);

        // flush in DONE must not suppress md_done
        @(negedge clk);
        drive(3'd5, 32'd100, 32'd7, 5'd14);
        sbq.push_back('{32'd14, 5'd14, cyc, 34});
        c0 = cyc;
        @(negedge clk);
        ex_start = 1'b0;
        while (cyc < c0 + 34) @(negedge clk);
        flush = 1'b1;
        #1 chk("done_under_flush", 32'(md_done), 32'd1);
        @(negedge clk);
        flush = 1'b0;

        // ex_start held through CALC/DONE: second op accepted only after DONE
        @(negedge clk);
        drive(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15);
        c0 = cyc;
        d0 = done_cnt;
        sbq.push_back('{ref_res(3'd3, 32'hDEAD_BEEF, 32'h1234_5678),
                        5'd15, c0, 34});
        @(negedge clk);
        drive(3'd4, 32'hFFFF_FC18, 32'd9, 5'd16);
        sbq.push_back('{ref_res(3'd4, 32'hFFFF_FC18, 32'd9), 5'd16,
                        c0 + 35, 34});
        while (cyc < c0 + 35) @(negedge clk);
        @(negedge clk);
        ex_start = 1'b0;
        for (int i = 0; i < 100 && done_cnt < d0 + 2; i++) @(negedge clk);
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

        // reset in mid-CALC discards the MUL
        @(negedge clk);
        drive(3'd0, 32'd1234, 32'd5678, 5'd17);
        c0 = cyc;
        d0 = done_cnt;
        @(negedge clk);
        ex_start = 1'b0;
        while (cyc < c0 + 15) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_stall", 32'(md_stall), 32'd0);
        chk("mrst_done", 32'(md_done), 32'd0);
        chk("mrst_result", md_result, 32'd0);
        chk("mrst_rdaddr", 32'(md_rdaddr), 32'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("mrst_no_done", 32'(done_cnt - d0), 32'd0);
        issue(3'd0, 32'd3, 32'd4, 5'd18);

        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            issue(3'($urandom_range(0, 7)), ra, rb, 5'($urandom_range(1, 31)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 ex_start  input  1  EX holds a valid M-extension instruction this cycle.
REQ-005 ex_func3  input  3  instruction bits [14:12]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 ex_op1  input  32  rs1 value (dividend or multiplicand).
REQ-007 ex_op2  input  32  rs2 value (divisor or multiplier).
REQ-008 ex_rdaddr  input  5  destination register.
REQ-009 flush  input  1  abort the in-flight operation (branch or jump taken).
REQ-010 md_stall  output  1  freeze IF, ID and the ID/EX register.
REQ-011 md_done  output  1  single-cycle pulse; result valid.
REQ-012 md_result  output  32  result, valid only while md_done=1.
REQ-013 md_rdaddr  output  5  destination register of md_result.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-015 IDLE: if ex_start=1 and flush=0, the block SHALL latch op1, op2, func3 and rdaddr, take operand magnitudes per signedness, clear the counter and go to CALC.
REQ-016 CALC SHALL run exactly 32 iterations, one per cycle: shift-add for multiplies, restoring shift-subtract for divides; it then goes to DONE.
REQ-017 Operation latency SHALL be 34 cycles: md_done is asserted in the 34th cycle after the accept edge.
REQ-018 Multiply SHALL use a 64-bit product. The result is negated when the operand signs differ: both operands signed for MULH, op1 only for MULHSU, none for MULHU/MUL. MUL returns [31:0]; the MULH variants return [63:32].
REQ-019 Divide SHALL use magnitudes. The quotient is negated when the signs differ (DIV). The remainder takes the dividend's sign (REM).
REQ-020 Divide by zero SHALL bypass CALC and go straight to DONE: quotient 0xFFFFFFFF, remainder = op1. Latency is 2 cycles.
REQ-021 Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM) SHALL bypass CALC: quotient 0x80000000, remainder 0. Latency is 2 cycles.
REQ-022 md_stall SHALL be combinationally high when (IDLE and ex_start and !flush), and registered-high throughout CALC. It SHALL be low in DONE and in IDLE otherwise.
REQ-023 DONE SHALL assert md_done for exactly one cycle with md_result/md_rdaddr, then return to IDLE.
REQ-024 ex_start while in CALC or DONE SHALL be ignored; no second operation is queued.
REQ-025 ex_start=1 in the DONE cycle SHALL be accepted in the following IDLE cycle, provided EX still holds it.
REQ-026 flush in CALC SHALL return the FSM to IDLE next cycle with no md_done. flush in DONE SHALL NOT suppress md_done.
REQ-027 md_result and md_rdaddr SHALL read 0 whenever md_done=0.

Reset
REQ-028 rst=0 at a clock edge SHALL force IDLE, counter 0, and all internal registers 0. md_stall, md_done, md_result and md_rdaddr SHALL all be 0.
REQ-029 Reset in mid-CALC SHALL discard the operation; no md_done follows.
REQ-030 Reset SHALL take priority over flush and ex_start.

Structure
REQ-031 The func3 encodings, state enum and the constants DIV0_Q (0xFFFFFFFF) and INT_MIN (0x80000000) SHALL live in the shared pipeline package.
REQ-032 A single sub-module, neg32 (two's-complement conditional negate), SHALL be instantiated for the operand and result sign fixes. The datapath SHALL otherwise stay flat.

Verification
REQ-033 MUL: op1=7, op2=-3 (0xFFFFFFFD). Required: md_done at cycle 34, result 0xFFFFFFEB, md_stall high for cycles 0-33.
REQ-034 MULH and MULHU with op1=op2=0x80000000. Required: MULH = 0x40000000, MULHU = 0x40000000. MULHSU with op1=0xFFFFFFFF, op2=2 -> 0xFFFFFFFF.
REQ-035 DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
REQ-036 DIV x/0 with op1=5. Required: md_done at cycle 2 with 0xFFFFFFFF; REM 5/0 -> 5. Overflow DIV 0x80000000/-1 -> 0x80000000 at cycle 2.
REQ-037 flush at cycle 10 of a DIVU. Required: IDLE by cycle 11, no md_done, md_stall low. Also: a second ex_start held during CALC is not accepted until after DONE.
REQ-038 rst=0 asserted at cycle 15 of a MUL. Required: all outputs 0 next cycle, no md_done. A fresh MUL 3*4 then returns 12 at cycle 34.
